// File: rtl/hiscore_ram_mux_if.sv
// Signal bundle between the hiscore engine, the game CPU and one work-RAM port.
// The slave modport is the mux's view; the master modport is the surrounding system's view.
interface hiscore_ram_mux_if #(
   parameter int AW = 10
);
   logic          hs_pause;
   logic [AW-1:0] hs_addr;
   logic [7:0]    hs_data;
   logic          hs_write;
   logic [7:0]    hs_din;
   logic [AW-1:0] cpu_addr;
   logic [7:0]    cpu_dout;
   logic          cpu_we;
   logic          cpu_idle;
   logic [7:0]    cpu_din;
   logic          cpu_halt;
   logic [AW-1:0] ram_addr;
   logic [7:0]    ram_d;
   logic          ram_we;
   logic [7:0]    ram_q;
   logic          hs_grant;
   logic          err_drop;

   modport slave (
      input  hs_pause, hs_addr, hs_data, hs_write,
      input  cpu_addr, cpu_dout, cpu_we, cpu_idle,
      input  ram_q,
      output hs_din, cpu_din, cpu_halt,
      output ram_addr, ram_d, ram_we,
      output hs_grant, err_drop
   );

   modport master (
      output hs_pause, hs_addr, hs_data, hs_write,
      output cpu_addr, cpu_dout, cpu_we, cpu_idle,
      output ram_q,
      input  hs_din, cpu_din, cpu_halt,
      input  ram_addr, ram_d, ram_we,
      input  hs_grant, err_drop
   );
endinterface

// File: rtl/hiscore_ram_mux.sv
// Halts the CPU and hands its work-RAM port to the hiscore engine; grant follows halt by settle cycles.
// hs_din is ram_q registered (address-to-data 2 cycles); the CPU is held off via cpu_halt, never the engine.
module hiscore_ram_mux #(
   parameter int AW      = 10,
   parameter int SETTLE  = 2,
   parameter int TIMEOUT = 1024
) (
   input logic              clk,
   input logic              reset_n,
   hiscore_ram_mux_if.slave bus
);
   typedef enum logic [2:0] {
      S_IDLE,
      S_HALTREQ,
      S_SETTLE,
      S_OWN,
      S_RELEASE
   } state_t;

   localparam logic [15:0] TMO_LIM = 16'(TIMEOUT);
   localparam logic [3:0]  SET_LD  = 4'(SETTLE);

   state_t        state_q, state_d;
   logic          sel_hs_q, sel_hs_d;
   logic          cpu_halt_q, cpu_halt_d;
   logic          hs_grant_q, hs_grant_d;
   logic          err_drop_q, err_drop_d;
   logic [15:0]   tmo_q, tmo_d;
   logic [3:0]    set_q, set_d;
   logic [7:0]    hs_din_q;
   logic [15:0]   tmo_inc;
   logic          tmo_hit;
   logic [AW-1:0] ram_addr_mux;

   assign tmo_inc = (tmo_q == 16'hFFFF) ? tmo_q : tmo_q + 16'd1;
   assign tmo_hit = (TIMEOUT != 0) && (tmo_inc == TMO_LIM);

   always_comb begin
      state_d    = state_q;
      sel_hs_d   = sel_hs_q;
      cpu_halt_d = cpu_halt_q;
      hs_grant_d = hs_grant_q;
      tmo_d      = tmo_q;
      set_d      = set_q;
      // Any engine write outside the granted window is dropped and remembered.
      err_drop_d = err_drop_q | (bus.hs_write & ~hs_grant_q);

      unique case (state_q)
         S_IDLE: begin
            if (bus.hs_pause) begin
               cpu_halt_d = 1'b1;
               tmo_d      = 16'd0;
               state_d    = S_HALTREQ;
            end
         end
         S_HALTREQ: begin
            tmo_d = tmo_inc;
            if (!bus.hs_pause) begin
               cpu_halt_d = 1'b0;
               state_d    = S_IDLE;
            end else if (bus.cpu_idle || tmo_hit) begin
               sel_hs_d = 1'b1;
               set_d    = SET_LD;
               state_d  = S_SETTLE;
            end
         end
         S_SETTLE: begin
            set_d = set_q - 4'd1;
            if (!bus.hs_pause) begin
               sel_hs_d = 1'b0;
               state_d  = S_RELEASE;
            end else if (set_q <= 4'd1) begin
               hs_grant_d = 1'b1;
               state_d    = S_OWN;
            end
         end
         S_OWN: begin
            if (!bus.hs_pause) begin
               hs_grant_d = 1'b0;
               sel_hs_d   = 1'b0;
               state_d    = S_RELEASE;
            end
         end
         S_RELEASE: begin
            // One cycle of halt with the CPU already back on the port.
            cpu_halt_d = 1'b0;
            state_d    = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         sel_hs_q   <= 1'b0;
         cpu_halt_q <= 1'b0;
         hs_grant_q <= 1'b0;
         err_drop_q <= 1'b0;
         tmo_q      <= 16'd0;
         set_q      <= 4'd0;
         hs_din_q   <= 8'd0;
      end else begin
         state_q    <= state_d;
         sel_hs_q   <= sel_hs_d;
         cpu_halt_q <= cpu_halt_d;
         hs_grant_q <= hs_grant_d;
         err_drop_q <= err_drop_d;
         tmo_q      <= tmo_d;
         set_q      <= set_d;
         hs_din_q   <= bus.ram_q;
      end
   end

   assign ram_addr_mux = sel_hs_q ? bus.hs_addr : bus.cpu_addr;
   assign bus.ram_addr = ram_addr_mux;
   assign bus.ram_d    = sel_hs_q ? bus.hs_data : bus.cpu_dout;
   assign bus.ram_we   = sel_hs_q ? (bus.hs_write & hs_grant_q) : bus.cpu_we;
   assign bus.hs_din   = hs_din_q;
   assign bus.cpu_din  = bus.ram_q;
   assign bus.cpu_halt = cpu_halt_q;
   assign bus.hs_grant = hs_grant_q;
   assign bus.err_drop = err_drop_q;
endmodule

// File: tb/tb_hiscore_ram_mux.sv
// Directed bench for hiscore_ram_mux: expectations are queued with a due cycle, a monitor checks them.
// A behavioural synchronous RAM (1-cycle read latency, read-old-data) sits on the RAM port.
module tb_hiscore_ram_mux;
   localparam int AW = 10;

   typedef enum int {SG_HALT, SG_GRANT, SG_ADDR, SG_D, SG_WE, SG_ERR, SG_HSDIN, SG_CPUDIN} sig_e;

   typedef struct {
      string       name;
      int          due;
      sig_e        sig;
      logic [15:0] val;
   } exp_t;

   logic clk;
   logic reset_n;
   int   cyc;
   int   checks;
   int   failures;
   exp_t sb[$];
   logic [7:0] mem [0:(1<<AW)-1];

   hiscore_ram_mux_if #(.AW(AW)) bus ();

   hiscore_ram_mux #(.AW(AW), .SETTLE(2), .TIMEOUT(8)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      for (int i = 0; i < (1<<AW); i++) mem[i] = 8'h00;
      mem[10'h040] = 8'h10;
   end

   always @(posedge clk) begin
      if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_d;
      bus.ram_q <= mem[bus.ram_addr];
   end

   function automatic logic [15:0] actual(input sig_e s);
      case (s)
         SG_HALT:   return {15'd0, bus.cpu_halt};
         SG_GRANT:  return {15'd0, bus.hs_grant};
         SG_ADDR:   return 16'(bus.ram_addr);
         SG_D:      return {8'd0, bus.ram_d};
         SG_WE:     return {15'd0, bus.ram_we};
         SG_ERR:    return {15'd0, bus.err_drop};
         SG_HSDIN:  return {8'd0, bus.hs_din};
         default:   return {8'd0, bus.cpu_din};
      endcase
   endfunction

   task automatic expect_at(input string nm, input int dly, input sig_e s, input logic [15:0] v);
      exp_t e;
      e.name = nm;
      e.due  = cyc + dly;
      e.sig  = s;
      e.val  = v;
      sb.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: every negedge, check all expectations due in this cycle.
   initial begin
      exp_t keep[$];
      logic [15:0] a;
      checks   = 0;
      failures = 0;
      forever begin
         @(negedge clk);
         keep = {};
         foreach (sb[i]) begin
            if (sb[i].due == cyc) begin
               a = actual(sb[i].sig);
               checks++;
               if (a !== sb[i].val) begin
                  failures++;
                  $display("FAIL %s: got %0h expected %0h (cycle %0d)", sb[i].name, a, sb[i].val, cyc);
               end
            end else if (sb[i].due < cyc) begin
               checks++;
               failures++;
               $display("FAIL %s: never checked, due cycle %0d now %0d", sb[i].name, sb[i].due, cyc);
            end else begin
               keep.push_back(sb[i]);
            end
         end
         sb = keep;
      end
   end

   initial begin
      reset_n      = 1'b0;
      bus.hs_pause = 1'b0;
      bus.hs_addr  = '0;
      bus.hs_data  = 8'h00;
      bus.hs_write = 1'b0;
      bus.cpu_addr = 10'h2AA;
      bus.cpu_dout = 8'h33;
      bus.cpu_we   = 1'b1;
      bus.cpu_idle = 1'b0;
      tick(); tick();

      // Reset state; RAM port follows the CPU.
      expect_at("rst_halt",  0, SG_HALT,  16'h0);
      expect_at("rst_grant", 0, SG_GRANT, 16'h0);
      expect_at("rst_err",   0, SG_ERR,   16'h0);
      expect_at("rst_hsdin", 0, SG_HSDIN, 16'h0);
      expect_at("rst_we",    0, SG_WE,    16'h1);
      expect_at("rst_addr",  0, SG_ADDR,  16'h2AA);
      expect_at("rst_d",     0, SG_D,     16'h33);
      tick();
      bus.cpu_we = 1'b0;
      reset_n    = 1'b1;
      tick();

      // Basic grant: pause at t0, idle at t0+3.
      bus.hs_pause = 1'b1;
      bus.hs_addr  = 10'h123;
      expect_at("bg_halt0",  0, SG_HALT,  16'h0);
      expect_at("bg_halt1",  1, SG_HALT,  16'h1);
      expect_at("bg_cpusel", 3, SG_ADDR,  16'h2AA);
      expect_at("bg_hssel",  4, SG_ADDR,  16'h123);
      expect_at("bg_grant0", 5, SG_GRANT, 16'h0);
      expect_at("bg_grant1", 6, SG_GRANT, 16'h1);
      tick(); tick(); tick();
      bus.cpu_idle = 1'b1;
      tick();
      bus.cpu_idle = 1'b0;
      tick(); tick();

      // Write-back, two cycles at 0x123.
      bus.hs_data  = 8'h5A;
      bus.hs_write = 1'b1;
      expect_at("wb_addr",  0, SG_ADDR, 16'h123);
      expect_at("wb_d0",    0, SG_D,    16'h5A);
      expect_at("wb_we0",   0, SG_WE,   16'h1);
      expect_at("wb_we1",   1, SG_WE,   16'h1);
      expect_at("wb_d1",    1, SG_D,    16'h5A);
      tick(); tick();

      // Read path from 0x040, and read-back of the written byte.
      bus.hs_write = 1'b0;
      bus.hs_addr  = 10'h040;
      expect_at("wb_weoff",   0, SG_WE,     16'h0);
      expect_at("wb_err",     0, SG_ERR,    16'h0);
      expect_at("rd_back5a",  1, SG_HSDIN,  16'h5A);
      expect_at("rd_cpudin",  1, SG_CPUDIN, 16'h10);
      expect_at("rd_hsdin",   2, SG_HSDIN,  16'h10);
      tick(); tick();

      // Release.
      bus.hs_pause = 1'b0;
      expect_at("rl_grant1", 0, SG_GRANT, 16'h1);
      expect_at("rl_hsaddr", 0, SG_ADDR,  16'h040);
      expect_at("rl_grant0", 1, SG_GRANT, 16'h0);
      expect_at("rl_halt1",  1, SG_HALT,  16'h1);
      expect_at("rl_cpuadr", 1, SG_ADDR,  16'h2AA);
      expect_at("rl_halt0",  2, SG_HALT,  16'h0);
      tick(); tick();

      // Timeout: cpu_idle stays low, TIMEOUT=8.
      bus.hs_pause = 1'b1;
      bus.hs_addr  = 10'h055;
      expect_at("to_halt",   1,  SG_HALT,  16'h1);
      expect_at("to_cpusel", 8,  SG_ADDR,  16'h2AA);
      expect_at("to_hssel",  9,  SG_ADDR,  16'h055);
      expect_at("to_grant0", 10, SG_GRANT, 16'h0);
      expect_at("to_grant1", 11, SG_GRANT, 16'h1);
      expect_at("to_err",    11, SG_ERR,   16'h0);
      repeat (11) tick();
      bus.hs_pause = 1'b0;
      expect_at("to_rlhalt1", 1, SG_HALT, 16'h1);
      expect_at("to_rlhalt0", 2, SG_HALT, 16'h0);
      tick(); tick();

      // Abort during HALTREQ.
      bus.hs_pause = 1'b1;
      expect_at("ab_halt1", 1, SG_HALT, 16'h1);
      expect_at("ab_halt2", 2, SG_HALT, 16'h1);
      expect_at("ab_halt0", 3, SG_HALT, 16'h0);
      expect_at("ab_addr2", 2, SG_ADDR, 16'h2AA);
      expect_at("ab_addr3", 3, SG_ADDR, 16'h2AA);
      tick(); tick();
      bus.hs_pause = 1'b0;
      tick(); tick();

      // Engine write while idle is dropped.
      bus.hs_write = 1'b1;
      bus.hs_data  = 8'hEE;
      bus.cpu_we   = 1'b0;
      expect_at("dr_we0",   0, SG_WE,   16'h0);
      expect_at("dr_err0",  0, SG_ERR,  16'h0);
      expect_at("dr_err1",  1, SG_ERR,  16'h1);
      expect_at("dr_addr",  0, SG_ADDR, 16'h2AA);
      tick();
      bus.cpu_we = 1'b1;
      expect_at("dr_cpuwe", 0, SG_WE, 16'h1);
      expect_at("dr_cpud",  0, SG_D,  16'h33);
      tick();
      bus.hs_write = 1'b0;
      bus.cpu_we   = 1'b0;
      expect_at("dr_sticky", 0, SG_ERR, 16'h1);
      tick();

      // Grant again, then async reset mid-write.
      bus.hs_pause = 1'b1;
      bus.cpu_idle = 1'b1;
      expect_at("ar_halt",  1, SG_HALT,  16'h1);
      expect_at("ar_cpusel",1, SG_ADDR,  16'h2AA);
      expect_at("ar_hssel", 2, SG_ADDR,  16'h055);
      expect_at("ar_grant", 4, SG_GRANT, 16'h1);
      tick(); tick();
      bus.cpu_idle = 1'b0;
      tick(); tick();
      bus.hs_addr  = 10'h0AB;
      bus.hs_data  = 8'h77;
      bus.hs_write = 1'b1;
      bus.cpu_we   = 1'b1;
      expect_at("ar_we",    0, SG_WE,   16'h1);
      expect_at("ar_addr",  0, SG_ADDR, 16'h0AB);
      expect_at("ar_d",     0, SG_D,    16'h77);
      expect_at("ar_halt1", 0, SG_HALT, 16'h1);
      tick();
      #2;
      reset_n = 1'b0;
      expect_at("ar_rhalt",  0, SG_HALT,  16'h0);
      expect_at("ar_rgrant", 0, SG_GRANT, 16'h0);
      expect_at("ar_rwe",    0, SG_WE,    16'h1);
      expect_at("ar_raddr",  0, SG_ADDR,  16'h2AA);
      expect_at("ar_rd",     0, SG_D,     16'h33);
      expect_at("ar_rerr",   0, SG_ERR,   16'h0);
      tick();
      bus.hs_write = 1'b0;
      bus.hs_pause = 1'b0;
      bus.cpu_we   = 1'b0;
      reset_n      = 1'b1;
      expect_at("pr_halt0", 1, SG_HALT, 16'h0);
      expect_at("pr_err0",  1, SG_ERR,  16'h0);
      tick();

      // FSM back in IDLE: a new pause halts after one cycle.
      bus.hs_pause = 1'b1;
      expect_at("pr_halt1",  1, SG_HALT,  16'h1);
      expect_at("pr_addr",   1, SG_ADDR,  16'h2AA);
      expect_at("pr_grant0", 2, SG_GRANT, 16'h0);
      tick(); tick();
      bus.hs_pause = 1'b0;
      repeat (4) tick();

      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
